// File: rtl/simd_alu_pkg.sv
// Shared definitions for the SIMD adder/subtractor pair: lane-mode encoding
// and lane widths, so both blocks decode data_mode identically.
package simd_alu_pkg;

    localparam int DATA_MODE_WIDTH = 2;
    localparam int LANE8_WIDTH     = 8;
    localparam int LANE16_WIDTH    = 16;

    typedef logic [DATA_MODE_WIDTH-1:0] data_mode_t;

    localparam data_mode_t MODE_8       = 2'd0;
    localparam data_mode_t MODE_16      = 2'd1;
    // Canonical value used internally for any undefined encoding.
    localparam data_mode_t MODE_INVALID = 2'd2;

endpackage

// File: rtl/simd_sub_lane16.sv
// Combinational 16-bit lane slice: one 16-bit difference, or two independent
// 8-bit differences with the borrow chain broken at bit 8. flag[1] is the
// high (or only) lane's flag, flag[0] the low 8-bit lane's flag.
module simd_sub_lane16
    import simd_alu_pkg::*;
(
    input  logic [LANE16_WIDTH-1:0] a,
    input  logic [LANE16_WIDTH-1:0] b,
    input  data_mode_t              mode,
    input  logic                    data_signed,
    output logic [LANE16_WIDTH-1:0] diff,
    output logic [1:0]              flag
);

    // One extra bit on each subtraction captures the unsigned borrow.
    logic [LANE8_WIDTH:0]  lo_ext;
    logic [LANE8_WIDTH:0]  hi_ext;
    logic [LANE16_WIDTH:0] full_ext;
    logic                  lo_flag;
    logic                  hi_flag;
    logic                  full_flag;

    assign lo_ext   = {1'b0, a[7:0]}  - {1'b0, b[7:0]};
    assign hi_ext   = {1'b0, a[15:8]} - {1'b0, b[15:8]};
    assign full_ext = {1'b0, a}       - {1'b0, b};

    // Signed overflow: operands of differing sign and the result sign flips away from a.
    assign lo_flag   = data_signed ? ((a[7]  != b[7])  && (lo_ext[7]    != a[7]))  : lo_ext[8];
    assign hi_flag   = data_signed ? ((a[15] != b[15]) && (hi_ext[7]    != a[15])) : hi_ext[8];
    assign full_flag = data_signed ? ((a[15] != b[15]) && (full_ext[15] != a[15])) : full_ext[16];

    // Select lane arrangement; undefined modes yield zero result and flags.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        diff = '0;
        flag = '0;
        case (mode)
            MODE_8: begin
                diff = {hi_ext[7:0], lo_ext[7:0]};
                flag = {hi_flag, lo_flag};
            end
            MODE_16: begin
                diff = full_ext[15:0];
                flag = {full_flag, 1'b0};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/simd_alu_subtractor_pipe.sv
// Two-stage SIMD lane-wise subtractor (result = a - b) with valid/ready on
// both sides. Stage 1 holds the operands, stage 2 holds result and flags.
// SIMD_DATA_WIDTH must be a multiple of 16.
module simd_alu_subtractor_pipe
    import simd_alu_pkg::*;
#(
    parameter int SIMD_DATA_WIDTH            = 256,
    parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]            a,
    input  logic [SIMD_DATA_WIDTH-1:0]            b,
    input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode,
    input  logic                                  data_signed,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SIMD_DATA_WIDTH-1:0]            result,
    output logic [SIMD_DATA_WIDTH/8-1:0]          flags
);

    localparam int NUM_LANE16 = SIMD_DATA_WIDTH / 16;

    logic                         s1_valid;
    logic [SIMD_DATA_WIDTH-1:0]   s1_a;
    logic [SIMD_DATA_WIDTH-1:0]   s1_b;
    data_mode_t                   s1_mode;
    logic                         s1_signed;
    logic                         s2_valid;
    logic                         s1_adv;
    logic                         s2_adv;
    data_mode_t                   in_mode;
    logic [SIMD_DATA_WIDTH-1:0]   lane_diff;
    logic [SIMD_DATA_WIDTH/8-1:0] lane_flags;

    // A stage may take new data when empty or when its content moves on.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Fold the external mode field onto the shared encoding at capture time.
    always_comb begin
        in_mode = MODE_INVALID;
        if (data_mode == SIMD_ADDER_DATA_MODE_WIDTH'(MODE_8)) begin
            in_mode = MODE_8;
        end else if (data_mode == SIMD_ADDER_DATA_MODE_WIDTH'(MODE_16)) begin
            in_mode = MODE_16;
        end
    end

    // Stage 1: capture operands only on an input transfer.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset as well, since result/flags must read zero after reset.
        if (rst) begin
            // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mode   <= MODE_8;
            s1_signed <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= a;
                s1_b      <= b;
                s1_mode   <= in_mode;
                s1_signed <= data_signed;
            end
        end
    end

    // Stage 2: register the lane differences and flags; hold them while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result <= lane_diff;
                flags  <= lane_flags;
            end
        end
    end

    for (genvar k = 0; k < NUM_LANE16; k++) begin : g_lane
        simd_sub_lane16 u_lane (
            .a           (s1_a[16*k +: 16]),
            .b           (s1_b[16*k +: 16]),
            .mode        (s1_mode),
            .data_signed (s1_signed),
            .diff        (lane_diff[16*k +: 16]),
            .flag        (lane_flags[2*k +: 2])
        );
    end

endmodule

// File: tb/tb_simd_alu_subtractor_pipe.sv
// Self-checking bench for simd_alu_subtractor_pipe: directed cases, a
// back-pressure stream, mid-flight reset and randomized traffic, all scored
// against an arithmetic reference model.
module tb_simd_alu_subtractor_pipe;

    localparam int W  = 256;
    localparam int FW = W / 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    data_mode;
    logic          data_signed;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [FW-1:0] flags;

    int total = 0;
    int bad   = 0;

    logic [FW+W-1:0] exp_q[$];
    logic            prev_stall = 1'b0;
    logic [W-1:0]    prev_result;
    logic [FW-1:0]   prev_flags;

    simd_alu_subtractor_pipe #(
        .SIMD_DATA_WIDTH            (W),
        .SIMD_ADDER_DATA_MODE_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .data_mode   (data_mode),
        .data_signed (data_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic per lane, flag from the true difference range.
    function automatic logic [FW+W-1:0] model(input logic [W-1:0] x_a, input logic [W-1:0] x_b,
                                               input logic [1:0] mode, input logic sgn);
        logic [W-1:0]  r;
        logic [FW-1:0] f;
        longint        x, y, d, lim;
        int            lw, n;
        logic          fl;
        r = '0;
        f = '0;
        if (mode == 2'd0 || mode == 2'd1) begin
            lw  = (mode == 2'd0) ? 8 : 16;
            n   = W / lw;
            lim = longint'(1) << (lw - 1);
            for (int k = 0; k < n; k++) begin
                x = 0;
                y = 0;
                for (int i = 0; i < lw; i++) begin
                    x[i] = x_a[k*lw + i];
                    y[i] = x_b[k*lw + i];
                end
                if (sgn) begin
                    if (x >= lim) x = x - 2 * lim;
                    if (y >= lim) y = y - 2 * lim;
                end
                d = x - y;
                for (int i = 0; i < lw; i++) r[k*lw + i] = d[i];
                fl = sgn ? (d < -lim || d > lim - 1) : (d < 0);
                if (lw == 8) f[k] = fl;
                else f[2*k + 1] = fl;
            end
        end
        return {f, r};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard and handshake-rule monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [FW+W-1:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, (exp_q.size() < 2) || out_ready);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_result", result, prev_result);
                check("stall_flags", flags, prev_flags);
            end
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_result", result, e[W-1:0]);
                    check("sb_flags", flags, e[FW+W-1:W]);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, data_mode, data_signed));
            prev_stall  = out_valid && !out_ready;
            prev_result = result;
            prev_flags  = flags;
        end
    end

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single beat on an empty pipe: out_valid must rise exactly two cycles after it is presented.
    task automatic run_directed(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [1:0] mode, input logic sgn,
                                input logic [W-1:0] exp_r, input logic [FW-1:0] exp_f);
        a           = va;
        b           = vb;
        data_mode   = mode;
        data_signed = sgn;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_flags"}, flags, exp_f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int            sent;
        int            cyc;
        logic          fired;
        logic [3:0]    bp_pat;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        data_mode   = 2'd0;
        data_signed = 1'b0;
        bp_pat      = 4'b1001;

        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, '0);
        check("rst_flags", flags, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        run_directed("u8_borrow", {32{8'h05}}, {32{8'h07}}, 2'd0, 1'b0, {32{8'hFE}}, 32'hFFFF_FFFF);
        run_directed("s8_ovf", 256'h1080, 256'h2001, 2'd0, 1'b1, 256'hF07F, 32'h1);
        run_directed("u16_lanes", 256'h0000_0100, 256'h0001_0001, 2'd1, 1'b0, 256'hFFFF_00FF, 32'h8);
        run_directed("s16_ovf", 256'h8000, 256'h0001, 2'd1, 1'b1, 256'h7FFF, 32'h2);
        run_directed("bad_mode", '1, '1, 2'd2, 1'b0, '0, '0);

        // Back-pressure stream: 8 beats, out_ready pattern 1,0,0,1 repeating.
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 200) begin
            out_ready   = bp_pat[cyc % 4];
            in_valid    = 1'b1;
            a           = rand_word();
            b           = rand_word();
            data_mode   = 2'($urandom_range(0, 1));
            data_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            fired = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fired) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        while (exp_q.size() != 0 && cyc < 400) begin
            out_ready = bp_pat[cyc % 4];
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp_sent", sent, 8);
        check("bp_drain", exp_q.size(), 0);
        idle(2);

        // Reset with two beats in flight: everything clears at once.
        a           = '1;
        b           = '0;
        data_mode   = 2'd0;
        data_signed = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #1 a = {W/8{8'h33}};
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_result", result, '0);
        check("arst_flags", flags, '0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_idle", out_valid, 1'b0);
        @(posedge clk);
        #1;
        run_directed("post_rst", {32{8'h05}}, {32{8'h07}}, 2'd0, 1'b0, {32{8'hFE}}, 32'hFFFF_FFFF);

        // Randomized traffic, operands changing every cycle, occasional invalid modes.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            a           = rand_word();
            b           = ($urandom_range(0, 7) == 0) ? a : rand_word();
            data_mode   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            data_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand_drain", exp_q.size(), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
